// File: rtl/ebr_pkg.sv
// Shared constants and read-engine state type for the PDPW16KD stream reader.
package ebr_pkg;

    localparam int unsigned EBR_DEPTH   = 512;
    localparam int unsigned EBR_AW      = 9;
    localparam int unsigned EBR_DW      = 36;
    localparam int unsigned EBR_ADR_LSB = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ebr_rd_state_t;

endpackage

// File: rtl/ebr_stream_reader_if.sv
// Control, EBR read-port and output-stream signals of ebr_stream_reader.
// CHECKSUM exists only when EBR_STREAM_READER_CHECKSUM_EN is defined.
interface ebr_stream_reader_if;
    import ebr_pkg::*;

    logic                          START;
    logic [EBR_AW-1:0]             START_ADDR;
    logic [EBR_AW:0]               COUNT;
    logic                          BUSY;
    logic                          DONE;
    logic [EBR_AW+EBR_ADR_LSB-1:0] ADR;
    logic                          CER;
    logic [2:0]                    CSR;
    logic [EBR_DW-1:0]             DO;
    logic [EBR_DW-1:0]             M_DATA;
    logic                          M_VALID;
    logic                          M_READY;
    logic                          M_LAST;
`ifdef EBR_STREAM_READER_CHECKSUM_EN
    logic [EBR_DW-1:0]             CHECKSUM;
`endif

    modport master (
        input  START, START_ADDR, COUNT, DO, M_READY,
        output BUSY, DONE, ADR, CER, CSR, M_DATA, M_VALID, M_LAST
`ifdef EBR_STREAM_READER_CHECKSUM_EN
        , output CHECKSUM
`endif
    );

    modport slave (
        output START, START_ADDR, COUNT, DO, M_READY,
        input  BUSY, DONE, ADR, CER, CSR, M_DATA, M_VALID, M_LAST
`ifdef EBR_STREAM_READER_CHECKSUM_EN
        , input CHECKSUM
`endif
    );

endinterface

// File: rtl/ebr_rd_skid.sv
// Two-entry FIFO holding captured EBR words and their last-word flag.
module ebr_rd_skid #(
    parameter int unsigned DW = 36
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic          o_valid,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_data0, r_data1;
    logic          r_last0, r_last1;
    logic [1:0]    r_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= i_data;
                        r_last0 <= i_last;
                    end else begin
                        r_data1 <= i_data;
                        r_last1 <= i_last;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: occupancy unchanged, head advances.
                    if (r_count == 2'd1) begin
                        r_data0 <= i_data;
                        r_last0 <= i_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= i_data;
                        r_last1 <= i_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data  = r_data0;
    assign o_last  = r_last0;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/ebr_stream_reader.sv
// Burst read-back engine for one 512x36 EBR, streaming words with valid/ready backpressure.
// Define EBR_STREAM_READER_CHECKSUM_EN to add the XOR CHECKSUM output.
module ebr_stream_reader #(
    parameter int unsigned EBR_DEPTH = 512,
    parameter int unsigned EBR_AW    = 9,
    parameter int unsigned EBR_DW    = 36,
    parameter logic [2:0]  CS_VALUE  = 3'b000
) (
    input logic                 CLK,
    input logic                 RST,
    ebr_stream_reader_if.master bus
);
    import ebr_pkg::*;

    ebr_rd_state_t     r_state, w_state_d;
    logic [EBR_AW-1:0] r_addr;
    logic [EBR_AW:0]   r_remain;
    logic              r_inflight, r_inflight_last, r_done;

    logic              w_start_ok, w_cer, w_pop, w_room, w_done_d;
    logic              w_valid, w_last;
    logic [EBR_DW-1:0] w_data;
    logic [1:0]        w_count, w_occ;

    assign w_pop      = w_valid && bus.M_READY;
    assign w_occ      = w_count + {1'b0, r_inflight};
    // Issue only if the new word is guaranteed a slot in the skid buffer.
    assign w_room     = (w_occ - {1'b0, w_pop}) < 2'd2;
    assign w_start_ok = bus.START && (r_state == IDLE) && !r_done;

    always_comb begin
        w_state_d = r_state;
        w_cer     = 1'b0;
        w_done_d  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    if (bus.COUNT == '0) w_done_d = 1'b1;
                    else                 w_state_d = RUN;
                end
            end
            RUN: begin
                if ((r_remain != '0) && w_room) begin
                    w_cer = 1'b1;
                    if (r_remain == (EBR_AW+1)'(1)) w_state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && w_last) begin
                    w_state_d = IDLE;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_d;
            r_done          <= w_done_d;
            r_inflight      <= w_cer;
            r_inflight_last <= w_cer && (r_remain == (EBR_AW+1)'(1));
            if (w_start_ok) begin
                r_addr   <= bus.START_ADDR;
                r_remain <= bus.COUNT;
            end else if (w_cer) begin
                r_addr   <= (r_addr == EBR_AW'(EBR_DEPTH - 1)) ? '0 : r_addr + 1'b1;
                r_remain <= r_remain - 1'b1;
            end
        end
    end

    ebr_rd_skid #(
        .DW (EBR_DW)
    ) u_skid (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (r_inflight),
        .i_data  (bus.DO),
        .i_last  (r_inflight_last),
        .i_pop   (w_pop),
        .o_data  (w_data),
        .o_last  (w_last),
        .o_valid (w_valid),
        .o_count (w_count)
    );

`ifdef EBR_STREAM_READER_CHECKSUM_EN
    logic [EBR_DW-1:0] r_checksum;

    always_ff @(posedge CLK) begin
        if (RST || w_start_ok) r_checksum <= '0;
        else if (w_pop)        r_checksum <= r_checksum ^ w_data;
    end

    assign bus.CHECKSUM = r_checksum;
`endif

    assign bus.BUSY    = (r_state != IDLE);
    assign bus.DONE    = r_done;
    assign bus.ADR     = {r_addr, {EBR_ADR_LSB{1'b0}}};
    assign bus.CER     = w_cer;
    assign bus.CSR     = CS_VALUE;
    assign bus.M_DATA  = w_data;
    assign bus.M_VALID = w_valid;
    assign bus.M_LAST  = w_last;

endmodule

// File: tb/tb_ebr_stream_reader.sv
// Randomized self-checking bench for ebr_stream_reader with a behavioural EBR and burst model.
module tb_ebr_stream_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ebr_stream_reader_if bus ();

    ebr_stream_reader dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [35:0] mem [512];

    // Registered EBR read port: data appears the cycle after CER.
    always @(posedge clk) if (bus.CER) bus.DO <= mem[bus.ADR[13:5]];

    int n_tests = 0;
    int n_fail  = 0;

    logic [35:0] hs_data[$];
    bit          hs_last[$];
    int          hs_cyc[$];
    logic [13:0] adr_log[$];
    int          done_cyc, busy_cyc, cer_cyc, valid_cyc, max_occ, stab_err, withdraw_err;
    logic        busy_at_done;
    logic [35:0] cks_at_done, cks_c1;

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        if (c >= 3 && c <= 9) return 1'b0;
        return (c % 2 == 0);
    endfunction

    function automatic logic [35:0] rnd36();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[35:0];
    endfunction

    // Drives one START and records what the DUT does until DONE (or stop_after handshakes).
    task automatic run_burst(input int addr, input int cnt, input int mode, input int stop_after);
        int issued, pops;
        logic pv, pr, pl;
        logic [35:0] pd;
        hs_data.delete(); hs_last.delete(); hs_cyc.delete(); adr_log.delete();
        done_cyc = -1; busy_cyc = 0; cer_cyc = 0; valid_cyc = 0; max_occ = 0;
        stab_err = 0; withdraw_err = 0; busy_at_done = 1'bx; cks_at_done = 'x; cks_c1 = 'x;
        issued = 0; pops = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        @(posedge clk); #1;
        bus.START_ADDR = 9'(addr);
        bus.COUNT      = 10'(cnt);
        bus.START      = 1'b1;
        bus.M_READY    = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            @(posedge clk); #1;
            bus.START   = 1'b0;
            bus.M_READY = ready_for(mode, c);
            #1;
            if (bus.CER) begin
                adr_log.push_back(bus.ADR);
                issued++;
                cer_cyc++;
            end
            if (bus.BUSY) busy_cyc++;
            if (pv && !pr) begin
                if (!bus.M_VALID) withdraw_err++;
                else if (bus.M_DATA !== pd || bus.M_LAST !== pl) stab_err++;
            end
            if (bus.M_VALID) valid_cyc++;
            if (bus.M_VALID && bus.M_READY) begin
                hs_data.push_back(bus.M_DATA);
                hs_last.push_back(bus.M_LAST);
                hs_cyc.push_back(c);
                pops++;
            end
            if (issued - pops > max_occ) max_occ = issued - pops;
`ifdef EBR_STREAM_READER_CHECKSUM_EN
            if (c == 1) cks_c1 = bus.CHECKSUM;
`endif
            pv = bus.M_VALID; pr = bus.M_READY; pd = bus.M_DATA; pl = bus.M_LAST;
            if (bus.DONE) begin
                done_cyc     = c;
                busy_at_done = bus.BUSY;
`ifdef EBR_STREAM_READER_CHECKSUM_EN
                cks_at_done  = bus.CHECKSUM;
`endif
                break;
            end
            if (stop_after > 0 && pops == stop_after) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if ({bus.BUSY, bus.DONE, bus.CER, bus.ADR, bus.M_VALID, bus.M_DATA, bus.M_LAST} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b cer=%b adr=%h valid=%b data=%h last=%b, need all 0",
                     bus.BUSY, bus.DONE, bus.CER, bus.ADR, bus.M_VALID, bus.M_DATA, bus.M_LAST);
        end
        n_tests++;
        if (bus.CSR !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_csr: got %b need 000", bus.CSR);
        end
`ifdef EBR_STREAM_READER_CHECKSUM_EN
        n_tests++;
        if (bus.CHECKSUM !== '0) begin
            n_fail++;
            $display("FAIL reset_checksum: got %h need 0", bus.CHECKSUM);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 512; i++) mem[i] = 36'h100 + 36'(i);
        run_burst(0, 4, 0, 0);
        n_tests++;
        if (hs_data.size() != 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d words need 4", hs_data.size());
        end
        for (int k = 0; k < hs_data.size() && k < 4; k++) begin
            n_tests++;
            if (hs_data[k] !== 36'h100 + 36'(k) || hs_last[k] !== (k == 3) || hs_cyc[k] != 3 + k) begin
                n_fail++;
                $display("FAIL basic_word%0d: got data=%h last=%b cyc=%0d need data=%h last=%b cyc=%0d",
                         k, hs_data[k], hs_last[k], hs_cyc[k], 36'h100 + 36'(k), (k == 3), 3 + k);
            end
        end
        for (int k = 0; k < adr_log.size(); k++) begin
            n_tests++;
            if (adr_log[k] !== 14'(k * 32)) begin
                n_fail++;
                $display("FAIL basic_adr%0d: got %h need %h", k, adr_log[k], 14'(k * 32));
            end
        end
        n_tests++;
        if (done_cyc != 7 || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got cyc=%0d busy=%b need cyc=7 busy=0", done_cyc, busy_at_done);
        end
    endtask

    task automatic test_wrap();
        int a;
        run_burst(510, 4, 0, 0);
        n_tests++;
        if (adr_log.size() != 4 || hs_data.size() != 4) begin
            n_fail++;
            $display("FAIL wrap_sizes: got adr=%0d words=%0d need 4/4", adr_log.size(), hs_data.size());
        end
        for (int k = 0; k < 4 && k < adr_log.size() && k < hs_data.size(); k++) begin
            a = (510 + k) % 512;
            n_tests++;
            if (adr_log[k] !== 14'(a * 32) || hs_data[k] !== mem[a]) begin
                n_fail++;
                $display("FAIL wrap_%0d: got adr=%h data=%h need adr=%h data=%h",
                         k, adr_log[k], hs_data[k], 14'(a * 32), mem[a]);
            end
        end
        n_tests++;
        if (done_cyc != 7) begin
            n_fail++;
            $display("FAIL wrap_done: got cyc=%0d need 7", done_cyc);
        end
    endtask

    task automatic test_backpressure();
        int addr;
        for (int i = 0; i < 512; i++) mem[i] = rnd36();
        addr = $urandom_range(0, 511);
        run_burst(addr, 8, 2, 0);
        n_tests++;
        if (hs_data.size() != 8) begin
            n_fail++;
            $display("FAIL bp_count: got %0d words need 8", hs_data.size());
        end
        for (int k = 0; k < hs_data.size() && k < 8; k++) begin
            n_tests++;
            if (hs_data[k] !== mem[(addr + k) % 512] || hs_last[k] !== (k == 7)) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %h/%b need %h/%b",
                         k, hs_data[k], hs_last[k], mem[(addr + k) % 512], (k == 7));
            end
        end
        n_tests++;
        if (stab_err != 0 || withdraw_err != 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d changes %0d withdrawals need 0/0", stab_err, withdraw_err);
        end
        n_tests++;
        if (max_occ > 2) begin
            n_fail++;
            $display("FAIL bp_outstanding: got %0d need <=2", max_occ);
        end
        n_tests++;
        if (hs_cyc.size() == 0 || done_cyc != hs_cyc[hs_cyc.size() - 1] + 1 || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: got cyc=%0d busy=%b need one after last handshake, busy=0",
                     done_cyc, busy_at_done);
        end
    endtask

    task automatic test_zero_count();
        int extra;
        run_burst(5, 0, 0, 0);
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #2;
            if (bus.BUSY || bus.CER || bus.M_VALID || bus.DONE) extra++;
        end
        n_tests++;
        if (done_cyc != 1) begin
            n_fail++;
            $display("FAIL zero_done: got cyc=%0d need 1", done_cyc);
        end
        n_tests++;
        if (cer_cyc + valid_cyc + busy_cyc + extra != 0) begin
            n_fail++;
            $display("FAIL zero_quiet: got cer=%0d valid=%0d busy=%0d later=%0d need all 0",
                     cer_cyc, valid_cyc, busy_cyc, extra);
        end
    endtask

    task automatic test_reset_mid_burst();
        int addr, late;
        for (int i = 0; i < 512; i++) mem[i] = rnd36();
        run_burst($urandom_range(0, 511), 6, 0, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.BUSY, bus.DONE, bus.CER, bus.ADR, bus.M_VALID, bus.M_DATA, bus.M_LAST} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: busy=%b done=%b cer=%b adr=%h valid=%b data=%h last=%b, need all 0",
                     bus.BUSY, bus.DONE, bus.CER, bus.ADR, bus.M_VALID, bus.M_DATA, bus.M_LAST);
        end
        late = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            if (bus.M_VALID || bus.BUSY || bus.DONE) late++;
        end
        n_tests++;
        if (late != 0) begin
            n_fail++;
            $display("FAIL midrst_flush: got %0d active cycles need 0", late);
        end
        addr = $urandom_range(0, 511);
        run_burst(addr, 2, 0, 0);
        n_tests++;
        if (hs_data.size() != 2 || done_cyc != 5) begin
            n_fail++;
            $display("FAIL midrst_restart: got words=%0d done=%0d need 2/5", hs_data.size(), done_cyc);
        end
        for (int k = 0; k < hs_data.size() && k < 2; k++) begin
            n_tests++;
            if (hs_data[k] !== mem[(addr + k) % 512] || hs_last[k] !== (k == 1) || hs_cyc[k] != 3 + k) begin
                n_fail++;
                $display("FAIL midrst_word%0d: got %h/%b cyc=%0d need %h/%b cyc=%0d", k, hs_data[k],
                         hs_last[k], hs_cyc[k], mem[(addr + k) % 512], (k == 1), 3 + k);
            end
        end
    endtask

    task automatic test_start_on_done();
        int act;
        run_burst($urandom_range(0, 511), 3, 0, 0);
        n_tests++;
        if (done_cyc != 6) begin
            n_fail++;
            $display("FAIL sod_done: got cyc=%0d need 6", done_cyc);
        end
        // Still inside the DONE cycle: this START must be ignored.
        bus.START = 1'b1;
        bus.COUNT = 10'd5;
        @(posedge clk); #1;
        bus.START = 1'b0;
        act = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (bus.BUSY || bus.CER || bus.M_VALID || bus.DONE) act++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (act != 0) begin
            n_fail++;
            $display("FAIL sod_ignored: got %0d active cycles need 0", act);
        end
    endtask

    task automatic test_random_bursts();
        int addr, cnt;
        logic [35:0] x;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 512; i++) mem[i] = rnd36();
            addr = $urandom_range(0, 511);
            cnt  = $urandom_range(1, 24);
            run_burst(addr, cnt, 1, 0);
            n_tests++;
            if (hs_data.size() != cnt || stab_err != 0 || withdraw_err != 0 || max_occ > 2) begin
                n_fail++;
                $display("FAIL rnd%0d_flow: got words=%0d stab=%0d wd=%0d occ=%0d need %0d/0/0/<=2",
                         it, hs_data.size(), stab_err, withdraw_err, max_occ, cnt);
            end
            x = '0;
            for (int k = 0; k < hs_data.size() && k < cnt; k++) begin
                x ^= mem[(addr + k) % 512];
                n_tests++;
                if (hs_data[k] !== mem[(addr + k) % 512] || hs_last[k] !== (k == cnt - 1)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_word%0d: got %h/%b need %h/%b", it, k, hs_data[k],
                             hs_last[k], mem[(addr + k) % 512], (k == cnt - 1));
                end
            end
            n_tests++;
            if (hs_cyc.size() == 0 || done_cyc != hs_cyc[hs_cyc.size() - 1] + 1) begin
                n_fail++;
                $display("FAIL rnd%0d_done: got cyc=%0d need one after last handshake", it, done_cyc);
            end
`ifdef EBR_STREAM_READER_CHECKSUM_EN
            n_tests++;
            if (cks_at_done !== x) begin
                n_fail++;
                $display("FAIL rnd%0d_checksum: got %h need %h", it, cks_at_done, x);
            end
`endif
        end
    endtask

    task automatic test_full_depth();
        int addr, bad;
        addr = $urandom_range(0, 511);
        run_burst(addr, 512, 0, 0);
        n_tests++;
        if (hs_data.size() != 512 || done_cyc != 515) begin
            n_fail++;
            $display("FAIL full_shape: got words=%0d done=%0d need 512/515", hs_data.size(), done_cyc);
        end
        bad = 0;
        for (int k = 0; k < hs_data.size() && k < 512; k++) begin
            if (hs_data[k] !== mem[(addr + k) % 512] || hs_last[k] !== (k == 511) || hs_cyc[k] != 3 + k)
                bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL full_words: got %0d bad words need 0", bad);
        end
    endtask

`ifdef EBR_STREAM_READER_CHECKSUM_EN
    task automatic test_checksum();
        mem[0] = 36'h1;
        mem[1] = 36'h2;
        mem[2] = 36'h4;
        run_burst(0, 3, 0, 0);
        n_tests++;
        if (cks_at_done !== 36'h7) begin
            n_fail++;
            $display("FAIL cks_done: got %h need 7", cks_at_done);
        end
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if (bus.CHECKSUM !== 36'h7) begin
            n_fail++;
            $display("FAIL cks_hold: got %h need 7", bus.CHECKSUM);
        end
        run_burst(0, 3, 0, 0);
        n_tests++;
        if (cks_c1 !== 36'h0 || cks_at_done !== 36'h7) begin
            n_fail++;
            $display("FAIL cks_restart: got c1=%h done=%h need 0/7", cks_c1, cks_at_done);
        end
    endtask
`endif

    initial begin
        bus.START      = 1'b0;
        bus.START_ADDR = '0;
        bus.COUNT      = '0;
        bus.M_READY    = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_reset_mid_burst();
        test_start_on_done();
        test_random_bursts();
        test_full_depth();
`ifdef EBR_STREAM_READER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
